// File: rtl/pcie_phy_pkg.sv
// Shared types and helpers for the PHY receive path: link rates, config-sequencer
// states, the applied-config record and the width/lane derivation functions.
package pcie_phy_pkg;

  typedef enum logic [2:0] {
    RATE_GEN1 = 3'd0,
    RATE_GEN2 = 3'd1,
    RATE_GEN3 = 3'd2,
    RATE_GEN4 = 3'd3,
    RATE_GEN5 = 3'd4
  } rate_speed_e;

  typedef enum logic [2:0] {
    ST_DOWN   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_APPLY  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_RUN    = 3'd5
  } cfg_st_e;

  localparam logic [5:0] PIPE_WIDTH_GEN1 = 6'd8;
  localparam logic [5:0] PIPE_WIDTH_GEN2 = 6'd16;
  localparam logic [5:0] PIPE_WIDTH_GEN3 = 6'd16;
  localparam logic [5:0] PIPE_WIDTH_GEN4 = 6'd32;
  localparam logic [5:0] PIPE_WIDTH_GEN5 = 6'd32;

  typedef struct packed {
    rate_speed_e rate;
    logic [5:0]  width;
    logic [5:0]  lanes;
    logic        reverse;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{rate: RATE_GEN1, width: PIPE_WIDTH_GEN1, lanes: 6'd1, reverse: 1'b0};

  function automatic logic [5:0] rate_to_pipe_width(input rate_speed_e rate);
    case (rate)
      RATE_GEN1: return PIPE_WIDTH_GEN1;
      RATE_GEN2: return PIPE_WIDTH_GEN2;
      RATE_GEN3: return PIPE_WIDTH_GEN3;
      RATE_GEN4: return PIPE_WIDTH_GEN4;
      RATE_GEN5: return PIPE_WIDTH_GEN5;
      default:   return PIPE_WIDTH_GEN1;
    endcase
  endfunction

  // Largest power of two not above min(width, max_lanes); a zero width yields 1.
  function automatic logic [5:0] legalize_lanes(input logic [5:0] width, input int unsigned max_lanes);
    int unsigned lim;
    int unsigned res;
    lim = (32'(width) < max_lanes) ? 32'(width) : max_lanes;
    res = 32'd1;
    for (int i = 0; i < 6; i++) begin
      if ((32'd1 << i) <= lim) res = 32'd1 << i;
    end
    return res[5:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pack_cfg_ctrl.sv
// Configuration sequencer for the RX byte packer: drains, flushes, reconfigures
// and re-arms the packer whenever the trained link parameters change.
module pack_cfg_ctrl
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int QUIET_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int FLUSH_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     phy_link_up_i,
  input  rate_speed_e              link_rate_i,
  input  logic [5:0]               link_width_i,
  input  logic                     lane_reverse_i,
  input  logic [MAX_NUM_LANES-1:0] rx_data_valid_i,
  input  logic                     packer_fifo_wr_i,
  output logic [MAX_NUM_LANES-1:0] data_valid_o,
  output logic                     packer_flush_o,
  output rate_speed_e              curr_data_rate_o,
  output logic [5:0]               pipe_width_o,
  output logic [5:0]               num_active_lanes_o,
  output logic                     lane_reverse_o,
  output logic                     cfg_busy_o,
  output logic                     cfg_done_o,
  output logic                     cfg_err_o,
  output logic                     drain_timeout_o
);

  localparam logic [5:0] DW_CAP       = 6'(DATA_WIDTH);
  localparam logic [7:0] QUIET_LAST   = 8'(QUIET_CYCLES - 1);
  localparam logic [7:0] QUIET_RELOAD = (QUIET_CYCLES >= 2) ? 8'(QUIET_CYCLES - 2) : 8'd0;
  localparam logic [7:0] TMO_LAST     = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] FLUSH_LAST   = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);

  cfg_st_e                  state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               quiet_cnt_q, quiet_cnt_d;
  logic [7:0]               tmo_cnt_q, tmo_cnt_d;
  cfg_t                     cfg_q, cfg_d;
  logic [MAX_NUM_LANES-1:0] valid_q, valid_d;
  logic                     flush_q, flush_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     tmo_pulse_q, tmo_pulse_d;

  cfg_t       tgt;
  logic [5:0] rate_w;
  logic       link_ok;
  logic       change_req;
  logic       rx_idle;

  always_comb begin
    link_ok    = phy_link_up_i && (link_width_i != 6'd0);
    rate_w     = rate_to_pipe_width(link_rate_i);
    tgt.rate    = link_rate_i;
    tgt.width   = (rate_w > DW_CAP) ? DW_CAP : rate_w;
    tgt.lanes   = legalize_lanes(link_width_i, MAX_NUM_LANES);
    tgt.reverse = lane_reverse_i;
    change_req = (tgt != cfg_q);
    rx_idle    = (rx_data_valid_i == '0);

    state_d     = state_q;
    cnt_d       = sat_inc(cnt_q);
    quiet_cnt_d = quiet_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    cfg_d       = cfg_q;
    tmo_pulse_d = 1'b0;

    case (state_q)
      ST_DOWN: state_d = ST_FLUSH;
      ST_DRAIN: begin
        tmo_cnt_d = sat_inc(tmo_cnt_q);
        // A packer write means the tail is leaving; jump the quiet count forward.
        if (packer_fifo_wr_i)  quiet_cnt_d = QUIET_RELOAD;
        else if (rx_idle)      quiet_cnt_d = sat_inc(quiet_cnt_q);
        else                   quiet_cnt_d = 8'd0;
        if (rx_idle && (quiet_cnt_q == QUIET_LAST)) begin
          state_d = ST_FLUSH;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_FLUSH;
          tmo_pulse_d = 1'b1;
        end
      end
      ST_FLUSH:  if (cnt_q == FLUSH_LAST) state_d = ST_APPLY;
      ST_APPLY: begin
        cfg_d   = tgt;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (change_req)                 state_d = ST_FLUSH;
        else if (cnt_q == SETTLE_LAST)  state_d = ST_RUN;
      end
      ST_RUN:    if (change_req) state_d = ST_DRAIN;
      default:   state_d = ST_DOWN;
    endcase

    // Link loss overrides everything; the applied config is kept until the next APPLY.
    if (!link_ok) begin
      state_d     = ST_DOWN;
      cfg_d       = cfg_q;
      tmo_pulse_d = 1'b0;
    end

    if (state_d != state_q) begin
      cnt_d       = 8'd0;
      quiet_cnt_d = 8'd0;
      tmo_cnt_d   = 8'd0;
    end

    valid_d = rx_data_valid_i & {MAX_NUM_LANES{(state_d == ST_RUN) || (state_d == ST_DRAIN)}};
    flush_d = (state_d == ST_DOWN) || (state_d == ST_FLUSH) || (state_d == ST_APPLY);
    busy_d  = (state_d != ST_RUN);
    done_d  = (state_d == ST_RUN) && (state_q != ST_RUN);
    err_d   = link_ok ? (err_q || (tgt.lanes != link_width_i)) : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_DOWN;
      cnt_q       <= 8'd0;
      quiet_cnt_q <= 8'd0;
      tmo_cnt_q   <= 8'd0;
      cfg_q       <= CFG_RESET;
      valid_q     <= '0;
      flush_q     <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cfg_q       <= cfg_d;
      valid_q     <= valid_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign data_valid_o       = valid_q;
  assign packer_flush_o     = flush_q;
  assign curr_data_rate_o   = cfg_q.rate;
  assign pipe_width_o       = cfg_q.width;
  assign num_active_lanes_o = cfg_q.lanes;
  assign lane_reverse_o     = cfg_q.reverse;
  assign cfg_busy_o         = busy_q;
  assign cfg_done_o         = done_q;
  assign cfg_err_o          = err_q;
  assign drain_timeout_o    = tmo_pulse_q;

endmodule

// File: tb/tb_pack_cfg_ctrl.sv
// Directed bench for pack_cfg_ctrl: link-up bring-up, drain timeout, quiet drain,
// lane legalization, link loss during settle and mid-run reset.
module tb_pack_cfg_ctrl;
  import pcie_phy_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  rate_speed_e rate;
  logic [5:0]  width;
  logic        rev;
  logic [3:0]  rx_valid;
  logic        fifo_wr;
  logic [3:0]  dv;
  logic        flush;
  rate_speed_e cur_rate;
  logic [5:0]  pipe_w;
  logic [5:0]  lanes;
  logic        rev_o;
  logic        busy;
  logic        done;
  logic        err;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pack_cfg_ctrl dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .phy_link_up_i      (link_up),
    .link_rate_i        (rate),
    .link_width_i       (width),
    .lane_reverse_i     (rev),
    .rx_data_valid_i    (rx_valid),
    .packer_fifo_wr_i   (fifo_wr),
    .data_valid_o       (dv),
    .packer_flush_o     (flush),
    .curr_data_rate_o   (cur_rate),
    .pipe_width_o       (pipe_w),
    .num_active_lanes_o (lanes),
    .lane_reverse_o     (rev_o),
    .cfg_busy_o         (busy),
    .cfg_done_o         (done),
    .cfg_err_o          (err),
    .drain_timeout_o    (tmo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_dv"},    32'(dv),       32'h0);
    chk({pfx, "_flush"}, 32'(flush),    32'h1);
    chk({pfx, "_rate"},  32'(cur_rate), 32'(RATE_GEN1));
    chk({pfx, "_pipe"},  32'(pipe_w),   32'd8);
    chk({pfx, "_lanes"}, 32'(lanes),    32'd1);
    chk({pfx, "_rev"},   32'(rev_o),    32'h0);
    chk({pfx, "_busy"},  32'(busy),     32'h1);
    chk({pfx, "_done"},  32'(done),     32'h0);
    chk({pfx, "_err"},   32'(err),      32'h0);
    chk({pfx, "_tmo"},   32'(tmo),      32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    link_up  = 1'b0;
    rate     = RATE_GEN1;
    width    = 6'd0;
    rev      = 1'b0;
    rx_valid = 4'h0;
    fifo_wr  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_reset_values("rst");

    // 1: bring-up at gen1 x4; done on the 8th edge after link-up
    link_up  = 1'b1;
    width    = 6'd4;
    rx_valid = 4'hF;
    repeat (7) step();
    chk("t1_done_early", 32'(done), 32'h0);
    chk("t1_dv_gated", 32'(dv), 32'h0);
    step();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_pipe", 32'(pipe_w), 32'd8);
    chk("t1_lanes", 32'(lanes), 32'd4);
    chk("t1_dv_f", 32'(dv), 32'hF);
    rx_valid = 4'h5;
    step();
    chk("t1_dv_5", 32'(dv), 32'h5);
    chk("t1_done_pulse", 32'(done), 32'h0);

    // 2: gen3 with continuous traffic -> drain times out after 64 cycles
    rx_valid = 4'hF;
    rate     = RATE_GEN3;
    step();
    chk("t2_drain_dv", 32'(dv), 32'hF);
    chk("t2_drain_busy", 32'(busy), 32'h1);
    chk("t2_pipe_old", 32'(pipe_w), 32'd8);
    repeat (63) step();
    chk("t2_tmo_early", 32'(tmo), 32'h0);
    step();
    chk("t2_tmo", 32'(tmo), 32'h1);
    chk("t2_flush", 32'(flush), 32'h1);
    chk("t2_dv_gated", 32'(dv), 32'h0);
    step();
    step();
    chk("t2_pipe_pre_apply", 32'(pipe_w), 32'd8);
    step();
    chk("t2_pipe", 32'(pipe_w), 32'd16);
    chk("t2_rate", 32'(cur_rate), 32'(RATE_GEN3));
    chk("t2_settle_flush", 32'(flush), 32'h0);
    chk("t2_tmo_pulse", 32'(tmo), 32'h0);
    repeat (3) step();
    chk("t2_settle_dv", 32'(dv), 32'h0);
    step();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_dv_run", 32'(dv), 32'hF);

    // 3: width 2 with rx idle -> drain exits after 4 idle cycles
    rx_valid = 4'h0;
    width    = 6'd2;
    step();
    repeat (3) step();
    chk("t3_drain_flush", 32'(flush), 32'h0);
    chk("t3_drain_busy", 32'(busy), 32'h1);
    step();
    chk("t3_flush", 32'(flush), 32'h1);
    chk("t3_tmo", 32'(tmo), 32'h0);
    repeat (3) step();
    chk("t3_lanes", 32'(lanes), 32'd2);
    chk("t3_err", 32'(err), 32'h0);
    repeat (4) step();
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_err_run", 32'(err), 32'h0);

    // 4: width 3 legalizes to 2 -> error, cleared by link down
    width = 6'd3;
    step();
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_lanes", 32'(lanes), 32'd2);
    chk("t4_busy", 32'(busy), 32'h0);
    link_up = 1'b0;
    step();
    chk("t4_err_clr", 32'(err), 32'h0);
    chk("t4_down_flush", 32'(flush), 32'h1);
    chk("t4_lanes_held", 32'(lanes), 32'd2);

    // 5: drop link during settle
    link_up  = 1'b1;
    width    = 6'd4;
    rx_valid = 4'hF;
    repeat (5) step();
    chk("t5_settle_flush", 32'(flush), 32'h0);
    chk("t5_lanes", 32'(lanes), 32'd4);
    link_up = 1'b0;
    step();
    chk("t5_state", 32'(dut.state_q), 32'(ST_DOWN));
    chk("t5_flush", 32'(flush), 32'h1);
    chk("t5_dv", 32'(dv), 32'h0);
    chk("t5_done", 32'(done), 32'h0);

    // 6: reset while running
    link_up = 1'b1;
    repeat (8) step();
    chk("t6_done", 32'(done), 32'h1);
    step();
    chk("t6_dv_run", 32'(dv), 32'hF);
    rst_n = 1'b0;
    step();
    chk_reset_values("t6");
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
